// File: rtl/adc_rcv_pkg.sv
// Shared definitions for the ADC receiver lane-alignment block:
// state encodings, default parameters and a counter-width helper.
package adc_rcv_pkg;

  localparam int         DEF_NLANES = 4;
  localparam int         DEF_DW     = 6;
  localparam logic [5:0] DEF_PAT    = 6'b111000;
  localparam int         DEF_SETTLE = 8;
  localparam int         DEF_NMATCH = 16;
  localparam int         DEF_DSTEPS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL,
    ST_WCAL,
    ST_DRESET,
    ST_ALIGN,
    ST_LOCKED,
    ST_FAIL
  } align_state_t;

  typedef enum logic [1:0] {
    LN_RUN,
    LN_ALIGNED,
    LN_FAILED
  } lane_state_t;

  // Width of a counter that must hold 0..maxval without wrapping (at least 1 bit).
  function automatic int cnt_width(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/adc_lane_align_if.sv
// Bundle of the SERDES/IODELAY-facing and status signals of adc_lane_align.
// The slave modport is the aligner; the master modport is whatever drives it.
interface adc_lane_align_if #(
  parameter int NLANES = 4,
  parameter int DW     = 6
);

  logic                 start;
  logic [NLANES*DW-1:0] din;
  logic                 busy;
  logic [NLANES-1:0]    bs;
  logic [NLANES-1:0]    dinc;
  logic                 dcal;
  logic                 drst;
  logic [NLANES*DW-1:0] dout;
  logic                 valid;
  logic                 done;
  logic [NLANES-1:0]    err;

  modport master (
    output start, din, busy,
    input  bs, dinc, dcal, drst, dout, valid, done, err
  );

  modport slave (
    input  start, din, busy,
    output bs, dinc, dcal, drst, dout, valid, done, err
  );

endinterface

// File: rtl/adc_lane_fsm.sv
// Per-lane aligner: waits for the data to settle, then counts PAT matches,
// stepping through bitslips and IODELAY increments on every mismatch.
module adc_lane_fsm
  import adc_rcv_pkg::*;
#(
  parameter int          DW     = DEF_DW,
  parameter logic [DW-1:0] PAT  = DW'(DEF_PAT),
  parameter int          SETTLE = DEF_SETTLE,
  parameter int          NMATCH = DEF_NMATCH,
  parameter int          DSTEPS = DEF_DSTEPS
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clear,
  input  logic [DW-1:0] word,
  output logic          bs,
  output logic          dinc,
  output logic          finished,
  output logic          failed
);

  localparam int SW = cnt_width(SETTLE);
  localparam int MW = cnt_width(NMATCH);
  localparam int LW = cnt_width(DW - 1);
  localparam int TW = cnt_width(DSTEPS);

  lane_state_t   state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [LW-1:0] slip_cnt, slip_nxt;
  logic [TW-1:0] step_cnt, step_nxt;
  logic          bs_nxt, dinc_nxt, finish_now, fail_now;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= LN_RUN;
      settle_cnt <= '0;
      match_cnt  <= '0;
      slip_cnt   <= '0;
      step_cnt   <= '0;
      bs         <= 1'b0;
      dinc       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      match_cnt  <= match_nxt;
      slip_cnt   <= slip_nxt;
      step_cnt   <= step_nxt;
      bs         <= bs_nxt;
      dinc       <= dinc_nxt;
    end
  end

  // A pulse resets the settle counter, so the pulse cycle itself is settle cycle 0.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    match_nxt  = match_cnt;
    slip_nxt   = slip_cnt;
    step_nxt   = step_cnt;
    bs_nxt     = 1'b0;
    dinc_nxt   = 1'b0;
    finish_now = 1'b0;
    fail_now   = 1'b0;
    if (clear) begin
      state_nxt  = LN_RUN;
      settle_nxt = '0;
      match_nxt  = '0;
      slip_nxt   = '0;
      step_nxt   = '0;
    end else if (en && state == LN_RUN) begin
      if (settle_cnt != SW'(SETTLE)) begin
        settle_nxt = settle_cnt + SW'(1);
      end else if (word == PAT) begin
        match_nxt = match_cnt + MW'(1);
        if (match_cnt == MW'(NMATCH - 1)) begin
          state_nxt  = LN_ALIGNED;
          finish_now = 1'b1;
        end
      end else begin
        match_nxt = '0;
        if (step_cnt == TW'(DSTEPS)) begin
          state_nxt  = LN_FAILED;
          finish_now = 1'b1;
          fail_now   = 1'b1;
        end else if (slip_cnt != LW'(DW - 1)) begin
          bs_nxt     = 1'b1;
          slip_nxt   = slip_cnt + LW'(1);
          settle_nxt = '0;
        end else begin
          dinc_nxt   = 1'b1;
          slip_nxt   = '0;
          step_nxt   = step_cnt + TW'(1);
          settle_nxt = '0;
        end
      end
    end
  end

  assign finished = (state != LN_RUN) || finish_now;
  assign failed   = (state == LN_FAILED) || fail_now;

endmodule

// File: rtl/adc_lane_align.sv
// ADC lane alignment controller: calibrates and resets the IODELAYs, then runs
// one adc_lane_fsm per lane until every lane is aligned or has given up.
module adc_lane_align
  import adc_rcv_pkg::*;
#(
  parameter int            NLANES = DEF_NLANES,
  parameter int            DW     = DEF_DW,
  parameter logic [DW-1:0] PAT    = DW'(DEF_PAT),
  parameter int            SETTLE = DEF_SETTLE,
  parameter int            NMATCH = DEF_NMATCH,
  parameter int            DSTEPS = DEF_DSTEPS
) (
  input logic             clk,
  input logic             rstn,
  adc_lane_align_if.slave bus
);

  align_state_t         state, state_nxt;
  logic                 wcal_cnt, wcal_nxt;
  logic [NLANES*DW-1:0] dout_q;
  logic [NLANES-1:0]    lane_bs, lane_dinc, lane_finished, lane_failed;
  logic                 lane_en, lane_clear, done_int;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wcal_cnt <= 1'b0;
      dout_q   <= '0;
    end else begin
      state    <= state_nxt;
      wcal_cnt <= wcal_nxt;
      dout_q   <= bus.din;
    end
  end

  // wcal_cnt enforces the two-cycle minimum in WCAL before BUSY is trusted.
  always_comb begin
    state_nxt = state;
    wcal_nxt  = 1'b0;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_CAL;
      ST_CAL:    state_nxt = ST_WCAL;
      ST_WCAL: begin
        wcal_nxt = 1'b1;
        if (wcal_cnt && !bus.busy) state_nxt = ST_DRESET;
      end
      ST_DRESET: state_nxt = ST_ALIGN;
      ST_ALIGN: begin
        if (&lane_finished) state_nxt = (|lane_failed) ? ST_FAIL : ST_LOCKED;
      end
      ST_LOCKED, ST_FAIL: if (bus.start) state_nxt = ST_CAL;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign lane_en    = (state == ST_ALIGN);
  assign lane_clear = (state == ST_DRESET);

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    adc_lane_fsm #(
      .DW     (DW),
      .PAT    (PAT),
      .SETTLE (SETTLE),
      .NMATCH (NMATCH),
      .DSTEPS (DSTEPS)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .en       (lane_en),
      .clear    (lane_clear),
      .word     (bus.din[g*DW +: DW]),
      .bs       (lane_bs[g]),
      .dinc     (lane_dinc[g]),
      .finished (lane_finished[g]),
      .failed   (lane_failed[g])
    );
  end

  // ERR is only meaningful once done, so it is masked to zero during a restart.
  assign done_int  = (state == ST_LOCKED) || (state == ST_FAIL);
  assign bus.bs    = lane_bs;
  assign bus.dinc  = lane_dinc;
  assign bus.dcal  = (state == ST_CAL);
  assign bus.drst  = (state == ST_DRESET);
  assign bus.valid = (state == ST_LOCKED);
  assign bus.done  = done_int;
  assign bus.err   = done_int ? lane_failed : '0;
  assign bus.dout  = dout_q;

endmodule

// File: tb/tb_adc_lane_align.sv
// Bench for adc_lane_align: a per-lane ISERDES/IODELAY data model reacting to
// BS/DINC, a DOUT scoreboard, and pulse counters checked per scenario.
module tb_adc_lane_align;
  import adc_rcv_pkg::*;

  localparam int            NLANES = 4;
  localparam int            DW     = 6;
  localparam int            SETTLE = 8;
  localparam int            NMATCH = 16;
  localparam int            DSTEPS = 32;
  localparam logic [DW-1:0] PAT    = 6'b111000;
  localparam logic [DW-1:0] NOISE  = 6'b010101;

  logic clk;
  logic rstn;

  adc_lane_align_if #(.NLANES(NLANES), .DW(DW)) bus ();

  adc_lane_align #(
    .NLANES (NLANES),
    .DW     (DW),
    .PAT    (PAT),
    .SETTLE (SETTLE),
    .NMATCH (NMATCH),
    .DSTEPS (DSTEPS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int check_count = 0;
  int error_count = 0;

  // Lane modes: 0 = PAT, 1 = PAT rotated (undone one bit per BS),
  // 2 = noise until 5 DINC seen, 3 = never matches.
  int lane_mode [NLANES];
  int rot_off   [NLANES];
  int dinc_seen [NLANES];
  int bs_cnt    [NLANES];
  int dinc_cnt  [NLANES];
  int dcal_cnt, drst_cnt, dcal_cycle, drst_cycle, valid_cycle, last_bs2, overlap_cnt;
  int cycle = 0;
  logic [NLANES*DW-1:0] din_next;
  logic [NLANES*DW-1:0] sb_q [$];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int n);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[DW-2:0], r[DW-1]};
    return r;
  endfunction

  function automatic logic [DW-1:0] lane_word(input int l);
    case (lane_mode[l])
      1:       return rotl(PAT, rot_off[l]);
      2:       return (dinc_seen[l] >= 5) ? PAT : NOISE;
      3:       return '0;
      default: return PAT;
    endcase
  endfunction

  function automatic int arr_sum(input int a [NLANES]);
    int s;
    s = 0;
    foreach (a[i]) s += a[i];
    return s;
  endfunction

  // Model + monitor: samples outputs mid-cycle, reacts to pulses, drives DIN.
  initial begin
    bus.din = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rstn) begin
        sb_q.delete();
        checkOutput("dout_in_reset", 64'(bus.dout), 64'(0));
      end else begin
        if (sb_q.size() > 0) checkOutput("dout", 64'(bus.dout), 64'(sb_q.pop_front()));
        for (int l = 0; l < NLANES; l++) begin
          if (bus.bs[l] && bus.dinc[l]) overlap_cnt++;
          if (bus.bs[l]) begin
            bs_cnt[l]++;
            rot_off[l] = (rot_off[l] + DW - 1) % DW;
            if (l == 2) begin
              if (last_bs2 >= 0) checkOutput("bs2_spacing", 64'(cycle - last_bs2), 64'(SETTLE + 1));
              last_bs2 = cycle;
            end
          end
          if (bus.dinc[l]) begin
            dinc_cnt[l]++;
            dinc_seen[l]++;
          end
        end
        if (bus.dcal) begin
          dcal_cnt++;
          dcal_cycle = cycle;
        end
        if (bus.drst) begin
          drst_cnt++;
          drst_cycle = cycle;
        end
        if (bus.valid && valid_cycle < 0) valid_cycle = cycle;
      end
      for (int l = 0; l < NLANES; l++) din_next[l*DW +: DW] = lane_word(l);
      bus.din = din_next;
      if (rstn) sb_q.push_back(din_next);
    end
  end

  task automatic setupLanes(input int m0, input int m1, input int m2, input int m3);
    lane_mode = '{m0, m1, m2, m3};
    for (int l = 0; l < NLANES; l++) begin
      rot_off[l]   = (lane_mode[l] == 1) ? 3 : 0;
      dinc_seen[l] = 0;
      bs_cnt[l]    = 0;
      dinc_cnt[l]  = 0;
    end
    dcal_cnt    = 0;
    drst_cnt    = 0;
    dcal_cycle  = -1;
    drst_cycle  = -1;
    valid_cycle = -1;
    last_bs2    = -1;
    overlap_cnt = 0;
  endtask

  task automatic applyStimulus(input int m0, input int m1, input int m2, input int m3);
    setupLanes(m0, m1, m2, m3);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.done && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput(tag, 64'(bus.done), 64'(1));
    @(posedge clk); #2;
  endtask

  initial begin
    int n;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.busy  = 1'b0;
    setupLanes(0, 0, 0, 0);
    #1;
    checkOutput("rst_valid", 64'(bus.valid), 64'(0));
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_err", 64'(bus.err), 64'(0));
    checkOutput("rst_pulses", 64'({bus.bs, bus.dinc, bus.dcal, bus.drst}), 64'(0));
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("idle_done", 64'(bus.done), 64'(0));
    checkOutput("idle_no_dcal", 64'(dcal_cnt), 64'(0));

    // All lanes already aligned
    applyStimulus(0, 0, 0, 0);
    waitDone("s1_done", 200);
    checkOutput("s1_dcal", 64'(dcal_cnt), 64'(1));
    checkOutput("s1_drst", 64'(drst_cnt), 64'(1));
    checkOutput("s1_cal_to_drst", 64'(drst_cycle - dcal_cycle), 64'(3));
    checkOutput("s1_bs", 64'(arr_sum(bs_cnt)), 64'(0));
    checkOutput("s1_dinc", 64'(arr_sum(dinc_cnt)), 64'(0));
    checkOutput("s1_valid", 64'(bus.valid), 64'(1));
    checkOutput("s1_err", 64'(bus.err), 64'(0));
    checkOutput("s1_lock_time", 64'(valid_cycle - drst_cycle), 64'(SETTLE + NMATCH + 1));

    // Lane 2 rotated by 3 bits
    applyStimulus(0, 0, 1, 0);
    waitDone("s2_done", 400);
    checkOutput("s2_bs2", 64'(bs_cnt[2]), 64'(3));
    checkOutput("s2_bs_all", 64'(arr_sum(bs_cnt)), 64'(3));
    checkOutput("s2_dinc", 64'(arr_sum(dinc_cnt)), 64'(0));
    checkOutput("s2_valid", 64'(bus.valid), 64'(1));
    checkOutput("s2_err", 64'(bus.err), 64'(0));

    // Lane 1 needs 5 delay steps
    applyStimulus(0, 2, 0, 0);
    waitDone("s3_done", 1000);
    checkOutput("s3_bs1", 64'(bs_cnt[1]), 64'(5 * (DW - 1)));
    checkOutput("s3_dinc1", 64'(dinc_cnt[1]), 64'(5));
    checkOutput("s3_bs_all", 64'(arr_sum(bs_cnt)), 64'(5 * (DW - 1)));
    checkOutput("s3_overlap", 64'(overlap_cnt), 64'(0));
    checkOutput("s3_valid", 64'(bus.valid), 64'(1));

    // Lane 0 never matches
    applyStimulus(3, 0, 0, 0);
    waitDone("s4_done", 4000);
    checkOutput("s4_dinc0", 64'(dinc_cnt[0]), 64'(DSTEPS));
    checkOutput("s4_bs0", 64'(bs_cnt[0]), 64'(DSTEPS * (DW - 1)));
    checkOutput("s4_err", 64'(bus.err), 64'(4'b0001));
    checkOutput("s4_valid", 64'(bus.valid), 64'(0));
    checkOutput("s4_done_hold", 64'(bus.done), 64'(1));
    checkOutput("s4_overlap", 64'(overlap_cnt), 64'(0));

    // BUSY held through WCAL, then a START during ALIGN
    setupLanes(0, 0, 0, 0);
    bus.busy  = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    checkOutput("s5_restart_clears_done", 64'({bus.done, bus.valid, bus.err}), 64'(0));
    repeat (21) @(posedge clk);
    #2;
    checkOutput("s5_no_drst_while_busy", 64'(drst_cnt), 64'(0));
    bus.busy = 1'b0;
    n = 0;
    while (drst_cnt == 0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("s5_drst_seen", 64'(drst_cnt), 64'(1));
    repeat (5) @(posedge clk);
    #2 bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    waitDone("s5_done", 200);
    checkOutput("s5_cal_to_drst", 64'(drst_cycle - dcal_cycle), 64'(22));
    checkOutput("s5_dcal_once", 64'(dcal_cnt), 64'(1));
    checkOutput("s5_lock_time", 64'(valid_cycle - drst_cycle), 64'(SETTLE + NMATCH + 1));
    checkOutput("s5_valid", 64'(bus.valid), 64'(1));

    // Reset in the middle of ALIGN, during a BS pulse
    applyStimulus(0, 2, 0, 0);
    n = 0;
    while (!bus.bs[1] && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput("s6_bs_seen", 64'(bus.bs[1]), 64'(1));
    rstn = 1'b0;
    #1;
    checkOutput("s6_pulses_zero", 64'({bus.bs, bus.dinc, bus.dcal, bus.drst}), 64'(0));
    checkOutput("s6_status_zero", 64'({bus.valid, bus.done, bus.err}), 64'(0));
    checkOutput("s6_dout_zero", 64'(bus.dout), 64'(0));
    setupLanes(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("s6_idle_no_dcal", 64'(dcal_cnt), 64'(0));
    checkOutput("s6_idle_no_pulse", 64'(arr_sum(bs_cnt) + arr_sum(dinc_cnt)), 64'(0));
    checkOutput("s6_idle_done", 64'(bus.done), 64'(0));
    applyStimulus(0, 0, 0, 0);
    waitDone("s6_done", 200);
    checkOutput("s6_dcal", 64'(dcal_cnt), 64'(1));
    checkOutput("s6_drst", 64'(drst_cnt), 64'(1));
    checkOutput("s6_lock_time", 64'(valid_cycle - drst_cycle), 64'(SETTLE + NMATCH + 1));
    checkOutput("s6_valid", 64'(bus.valid), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/adc_lane_align.md
ADC_LANE_ALIGN -- requirements
Module: adc_lane_align

Interface
REQ-001 Parameter NLANES, default 4, number of ADC data lanes (1..16).
REQ-002 Parameter DW, default 6, deserialized word width per lane (2..8).
REQ-003 Parameter PAT, default 6'b111000 (DW bits), training word expected on every lane.
REQ-004 Parameter SETTLE, default 8, cycles to wait after any BS/DINC before re-sampling a lane.
REQ-005 Parameter NMATCH, default 16, consecutive PAT matches needed to declare a lane aligned.
REQ-006 Parameter DSTEPS, default 32, max IODELAY increments per lane before the lane is declared failed.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-008 CLK  in  1  fabric clock; SERDES CLKDIV domain; all logic on rising edge.
REQ-009 RSTN  in  1  asynchronous active-low reset.
REQ-010 START  in  1  one-cycle request to (re)start alignment.
REQ-011 DIN  in  NLANES*DW  deserialized lane words; lane i = DIN[i*DW +: DW].
REQ-012 BUSY  in  1  OR of IODELAY BUSY outputs.
REQ-013 BS  out  NLANES  per-lane one-cycle bitslip pulse to ISERDES.
REQ-014 DINC  out  NLANES  per-lane one-cycle delay-increment pulse to IODELAY.
REQ-015 DCAL  out  1  one-cycle calibrate pulse to all IODELAYs.
REQ-016 DRST  out  1  one-cycle delay-reset pulse to all IODELAYs.
REQ-017 DOUT  out  NLANES*DW  registered copy of DIN.
REQ-018 VALID  out  1  high while state LOCKED.
REQ-019 DONE  out  1  high in LOCKED or FAIL.
REQ-020 ERR  out  NLANES  per-lane failure flag, valid when DONE.

Function
REQ-021 Top FSM states: IDLE, CAL, WCAL, DRESET, ALIGN, LOCKED, FAIL.
REQ-022 IDLE: on START -> CAL; START in CAL/WCAL/DRESET/ALIGN SHALL be ignored; START in LOCKED/FAIL -> CAL and clears ERR, VALID, DONE next cycle.
REQ-023 CAL: DCAL=1 for one cycle -> WCAL.
REQ-024 WCAL: wait min 2 cycles, then until BUSY=0 -> DRESET.
REQ-025 DRESET: DRST=1 for one cycle; all lane counters cleared -> ALIGN.
REQ-026 ALIGN: all lane aligners run in parallel; exit when every lane is aligned or failed; -> LOCKED if ERR==0, else FAIL.
REQ-027 Lane aligner: after SETTLE idle cycles, compares its word with PAT each cycle.
REQ-028 Match: match counter +1; at NMATCH lane aligned, frozen until restart.
REQ-029 Mismatch: match counter cleared; if slip count < DW-1, BS pulse, slip count +1; else slip count cleared, DINC pulse, step count +1.
REQ-030 Every BS or DINC pulse SHALL restart the SETTLE wait; BS and DINC never asserted together on one lane.
REQ-031 Step count reaching DSTEPS with a mismatch: ERR[i]=1, lane failed, no further pulses.
REQ-032 BS, DINC, DCAL, DRST SHALL be zero outside their defined pulse cycles.
REQ-033 DOUT latency exactly 1 cycle from DIN, in every state.
REQ-034 Counter widths: match clog2(NMATCH+1), slip clog2(DW), step clog2(DSTEPS+1), settle clog2(SETTLE+1); no wrap.

Reset
REQ-035 RSTN low: state IDLE; BS, DINC, DCAL, DRST, VALID, DONE, ERR, DOUT all zero; lane counters zero.
REQ-036 RSTN asserted mid-operation SHALL abort immediately; no pulse may complete after reset; deassertion returns to IDLE awaiting START.

Structure
REQ-037 State encoding and default parameter constants in shared package adc_rcv_pkg.
REQ-038 One sub-module adc_lane_fsm (per-lane settle/match/slip/step logic), instantiated NLANES times via generate.

Verification
REQ-039 All lanes already presenting PAT, START -> DCAL, DRST pulses, zero BS/DINC, VALID=1 after SETTLE+NMATCH cycles in ALIGN.
REQ-040 Lane 2 word rotated by 3 bits (model ISERDES rotation per BS) -> exactly 3 BS pulses on lane 2, each spaced SETTLE+1 cycles, then LOCKED, ERR=0.
REQ-041 Lane 1 matches only after 5 DINC (delay model) -> lane 1 shows 5*(DW-1)=25 BS and 5 DINC, LOCKED.
REQ-042 Lane 0 never matches -> DSTEPS=32 DINC pulses, ERR=4'b0001, FAIL, DONE=1, VALID=0.
REQ-043 BUSY held high 20 cycles in WCAL -> DRST delayed until BUSY low; START during ALIGN ignored.
REQ-044 RSTN low during ALIGN -> all outputs zero same cycle; START after release -> full sequence repeats.
